viterbi_decoder: RTL and testbench

VITERBI_DECODER -- requirements
Module: viterbi_decoder

---
 rtl/viterbi_pkg.sv | 31 +++
 rtl/viterbi_acs.sv | 31 +++
 rtl/viterbi_decoder.sv | 157 +++++++++++++++
 tb/tb_viterbi_decoder.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/viterbi_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : viterbi_pkg
//  Purpose  : Shared constants, types and helpers for the K=3, rate-1/2
//             Viterbi decoder (code generators, state index, metric init).
//  Revision : 1.0  initial release
// ============================================================================
package viterbi_pkg;

   localparam int         NUM_STATES = 4;
   // Generator taps ordered {d, s0, s1}
   localparam logic [2:0] G0 = 3'b111;
   localparam logic [2:0] G1 = 3'b101;

   // State index {s1, s0}
   typedef logic [1:0] state_idx_t;

   // Initial path metric: state 0 is certain, all others start disfavoured
   function automatic int pm_init(input int pm_w, input int idx);
      return (idx == 0) ? 0 : (1 << (pm_w - 1));
   endfunction

   // Expected code pair {G0 bit, G1 bit} for input d leaving predecessor p
   function automatic logic [1:0] branch_code(input logic d, input state_idx_t p);
      logic [2:0] taps;
      taps = {d, p[0], p[1]};
      return {^(taps & G0), ^(taps & G1)};
   endfunction

endpackage
`default_nettype wire

// File: rtl/viterbi_acs.sv
`default_nettype none
// ============================================================================
//  Module   : viterbi_acs
//  Purpose  : Add-compare-select for one trellis state. Candidate 0 comes from
//             predecessor {0,a}, candidate 1 from {1,a}; ties pick candidate 0.
//  Revision : 1.0  initial release
// ============================================================================
module viterbi_acs #(
   parameter int PM_W = 5
) (
   input  logic [PM_W-1:0] pm0_i,
   input  logic [PM_W-1:0] pm1_i,
   input  logic [1:0]      bm0_i,
   input  logic [1:0]      bm1_i,
   output logic [PM_W:0]   pm_o,
   output logic            dec_o
);

   logic [PM_W:0] w_cand0;
   logic [PM_W:0] w_cand1;

   // Extra bit keeps the un-normalised sum from overflowing
   always_comb begin
      w_cand0 = {1'b0, pm0_i} + (PM_W+1)'(bm0_i);
      w_cand1 = {1'b0, pm1_i} + (PM_W+1)'(bm1_i);
      dec_o   = (w_cand1 < w_cand0);
      pm_o    = dec_o ? w_cand1 : w_cand0;
   end

endmodule
`default_nettype wire

// File: rtl/viterbi_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : viterbi_decoder
//  Purpose  : Serial-input K=3 rate-1/2 Viterbi decoder using register
//             exchange survivors of TB_DEPTH bits; emits one decoded bit per
//             symbol once the survivors are full.
//  Revision : 1.0  initial release
// ============================================================================
module viterbi_decoder
   import viterbi_pkg::*;
#(
   parameter int TB_DEPTH = 16,
   parameter int PM_W     = 5
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic code_in,
   input  logic code_valid,
   output logic data_out,
   output logic valid
);

   localparam int                CNT_W   = $clog2(TB_DEPTH);
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TB_DEPTH - 1);
   localparam logic [PM_W:0]     PM_SAT  = (PM_W+1)'((1 << PM_W) - 1);

   logic [PM_W-1:0]     pm_q     [NUM_STATES];
   logic [PM_W-1:0]     pm_d     [NUM_STATES];
   logic [TB_DEPTH-1:0] surv_q   [NUM_STATES];
   logic [TB_DEPTH-1:0] surv_d   [NUM_STATES];
   logic                phase_q, phase_d;
   logic                r0_q, r0_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                data_q, data_d;
   logic                valid_q, valid_d;

   logic [PM_W:0]       w_sum    [NUM_STATES];
   logic [TB_DEPTH-1:0] w_surv   [NUM_STATES];
   logic [PM_W:0]       w_min;
   logic [PM_W:0]       w_diff;
   state_idx_t          w_best;

   for (genvar s = 0; s < NUM_STATES; s++) begin : g_state
      // State {a,d}: predecessors are {0,a} (index a) and {1,a} (index 2+a)
      localparam int A  = s / 2;
      localparam int D  = s % 2;
      localparam int P0 = A;
      localparam int P1 = 2 + A;

      logic [1:0]          w_exp0, w_exp1;
      logic [1:0]          w_bm0, w_bm1;
      logic                w_dec;
      logic [TB_DEPTH-1:0] w_win;

      // Hamming distance between received pair and each branch label
      always_comb begin
         w_exp0 = branch_code(1'(D), state_idx_t'(P0));
         w_exp1 = branch_code(1'(D), state_idx_t'(P1));
         w_bm0  = {1'b0, r0_q ^ w_exp0[1]} + {1'b0, code_in ^ w_exp0[0]};
         w_bm1  = {1'b0, r0_q ^ w_exp1[1]} + {1'b0, code_in ^ w_exp1[0]};
      end

      viterbi_acs #(.PM_W(PM_W)) u_acs (
         .pm0_i (pm_q[P0]),
         .pm1_i (pm_q[P1]),
         .bm0_i (w_bm0),
         .bm1_i (w_bm1),
         .pm_o  (w_sum[s]),
         .dec_o (w_dec)
      );

      // Register exchange: inherit winner's history, append this state's input bit
      always_comb begin
         w_win     = w_dec ? surv_q[P1] : surv_q[P0];
         w_surv[s] = (w_win << 1) | TB_DEPTH'(D);
      end
   end

   // Next-state logic: pair bits into symbols, normalise metrics, emit decisions
   always_comb begin
      phase_d = phase_q;
      r0_d    = r0_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      valid_d = 1'b0;
      pm_d    = pm_q;
      surv_d  = surv_q;
      w_diff  = '0;

      w_min  = w_sum[0];
      w_best = '0;
      for (int i = 1; i < NUM_STATES; i++) begin
         if (w_sum[i] < w_min) begin
            w_min  = w_sum[i];
            w_best = state_idx_t'(i);
         end
      end

      if (clear) begin
         phase_d = 1'b0;
         r0_d    = 1'b0;
         cnt_d   = '0;
         data_d  = 1'b0;
         for (int i = 0; i < NUM_STATES; i++) begin
            pm_d[i]   = PM_W'(pm_init(PM_W, i));
            surv_d[i] = '0;
         end
      end else if (code_valid) begin
         if (!phase_q) begin
            r0_d    = code_in;
            phase_d = 1'b1;
         end else begin
            phase_d = 1'b0;
            for (int i = 0; i < NUM_STATES; i++) begin
               w_diff    = w_sum[i] - w_min;
               pm_d[i]   = (w_diff > PM_SAT) ? PM_SAT[PM_W-1:0] : w_diff[PM_W-1:0];
               surv_d[i] = w_surv[i];
            end
            if (cnt_q == CNT_MAX) begin
               valid_d = 1'b1;
               data_d  = w_surv[w_best][TB_DEPTH-1];
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
      end
   end

   // State register with asynchronous reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         phase_q <= 1'b0;
         r0_q    <= 1'b0;
         cnt_q   <= '0;
         data_q  <= 1'b0;
         valid_q <= 1'b0;
         for (int i = 0; i < NUM_STATES; i++) begin
            pm_q[i]   <= PM_W'(pm_init(PM_W, i));
            surv_q[i] <= '0;
         end
      end else begin
         phase_q <= phase_d;
         r0_q    <= r0_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         pm_q    <= pm_d;
         surv_q  <= surv_d;
      end
   end

   assign data_out = data_q;
   assign valid    = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_viterbi_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_viterbi_decoder
//  Purpose  : Scoreboard bench for viterbi_decoder with directed streams.
//  Revision : 1.0  initial release
// ============================================================================
module tb_viterbi_decoder;

   localparam int TB_DEPTH = 16;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic clear = 1'b0;
   logic code_in = 1'b0;
   logic code_valid = 1'b0;
   logic data_out;
   logic valid;

   int   n_checks = 0;
   int   n_fail   = 0;
   logic exp_q[$];
   logic last_out = 1'b0;

   // Bench-side encoder and framing state
   logic enc_s0 = 1'b0, enc_s1 = 1'b0;
   logic ph = 1'b0;
   int   sym_k = 0;

   viterbi_decoder #(.TB_DEPTH(TB_DEPTH), .PM_W(5)) dut (
      .clk        (clk),
      .reset      (reset),
      .clear      (clear),
      .code_in    (code_in),
      .code_valid (code_valid),
      .data_out   (data_out),
      .valid      (valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every strobe must match the oldest expected decoded bit
   always @(negedge clk) begin
      if (valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_valid", 1, 0);
         end else begin
            logic e;
            e = exp_q.pop_front();
            chk("data_out", int'(data_out), int'(e));
            last_out = e;
         end
      end
   end

   task automatic frame_restart();
      enc_s0 = 1'b0; enc_s1 = 1'b0; ph = 1'b0; sym_k = 0;
   endtask

   task automatic send_bit(input logic b, input logic v);
      code_in = b; code_valid = v;
      @(posedge clk); #1;
      code_valid = 1'b0;
      if (v && ph) begin
         chk("valid_after_r1", int'(valid), int'(sym_k >= TB_DEPTH-1));
         ph = 1'b0;
         sym_k++;
      end else begin
         if (v) ph = 1'b1;
         chk("valid_low", int'(valid), 0);
         if (!v) chk("data_hold", int'(data_out), int'(last_out));
      end
   endtask

   task automatic send_sym(input logic d, input logic flip0, input int gap);
      logic g0, g1;
      g0 = d ^ enc_s0 ^ enc_s1;
      g1 = d ^ enc_s1;
      enc_s1 = enc_s0; enc_s0 = d;
      send_bit(g0 ^ flip0, 1'b1);
      repeat (gap) send_bit(1'b0, 1'b0);
      send_bit(g1, 1'b1);
      repeat (gap) send_bit(1'b0, 1'b0);
   endtask

   function automatic logic pat_bit(input int i);
      logic [3:0] m;
      m = 4'b1101;   // data 1,0,1,1 in symbol order
      return (i < 4) ? m[i] : 1'b0;
   endfunction

   // Pattern of 20 symbols: 1,0,1,1 then zeros; decodes 1,0,1,1,0
   task automatic pattern(input int flip_sym, input int gap);
      exp_q.push_back(1'b1); exp_q.push_back(1'b0);
      exp_q.push_back(1'b1); exp_q.push_back(1'b1);
      exp_q.push_back(1'b0);
      for (int i = 0; i < 20; i++)
         send_sym(pat_bit(i), (i == flip_sym), gap);
   endtask

   task automatic do_clear();
      clear = 1'b1; code_valid = 1'b1; code_in = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0; code_valid = 1'b0;
      frame_restart();
      chk("clear_valid", int'(valid), 0);
   endtask

   task automatic drain(input string name);
      repeat (3) @(posedge clk);
      #1;
      chk(name, exp_q.size(), 0);
   endtask

   initial begin
      #12;
      chk("reset_valid", int'(valid), 0);
      chk("reset_data", int'(data_out), 0);
      @(posedge clk); #1;
      reset = 1'b0;
      frame_restart();

      // All-zero stream: 24 symbols -> 9 zero strobes from symbol 15
      for (int i = 0; i < 9; i++) exp_q.push_back(1'b0);
      for (int i = 0; i < 24; i++) send_sym(1'b0, 1'b0, 0);
      drain("zeros_drain");

      // Clean pattern
      do_clear();
      pattern(-1, 0);
      drain("clean_drain");

      // One channel error on r0 of symbol 1
      do_clear();
      pattern(1, 0);
      drain("flip_drain");

      // Half symbol discarded by clear
      do_clear();
      send_bit(1'b1, 1'b1);
      do_clear();
      pattern(-1, 0);
      drain("halfsym_drain");

      // Gapped input, two idle cycles after every accepted bit
      do_clear();
      pattern(-1, 2);
      drain("gap_drain");

      // Mid-frame reset: decode 1,0,1 then reset during a half symbol
      do_clear();
      exp_q.push_back(1'b1); exp_q.push_back(1'b0); exp_q.push_back(1'b1);
      for (int i = 0; i < 18; i++) send_sym(pat_bit(i), 1'b0, 0);
      chk("pre_reset_data", int'(data_out), 1);
      send_bit(1'b1, 1'b1);
      reset = 1'b1;
      #2;
      chk("async_reset_valid", int'(valid), 0);
      chk("async_reset_data", int'(data_out), 0);
      last_out = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      frame_restart();
      pattern(-1, 0);
      drain("reset_drain");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
